// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU host sequencer.
// Holds the sequencer state encoding and matrix packing helpers.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        GAP,
        READ,
        RESP
    } seq_state_t;

    localparam int N_ELEM = 4;
    localparam int ELEM_W = 8;
    localparam int MAT_W  = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic logic [ELEM_W-1:0] get_elem(
        input logic [MAT_W-1:0] m,
        input logic [1:0]       i
    );
        return m[i*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/tpu_host_sequencer_if.sv
// Host-side command/response handshake bundle.
// master = host bus / command FIFO, slave = sequencer.
interface tpu_host_sequencer_if;
    import tpu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [MAT_W-1:0] cmd_a;
    logic [MAT_W-1:0] cmd_b;
    logic             res_valid;
    logic             res_ready;
    logic [MAT_W-1:0] res_data;
    logic             res_timeout;

    modport master (
        output cmd_valid, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_timeout
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_timeout
    );

endinterface

// File: rtl/tpu_host_sequencer.sv
// Host initiator for the 2x2 systolic matmul controller.
// Loads A/B byte-serially, waits for done, reads C back.
module tpu_host_sequencer
    import tpu_pkg::*;
#(
    parameter int READ_DELAY   = 2,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    tpu_host_sequencer_if.slave host,
    output logic        busy_o,
    output logic        load_en_o,
    output logic        load_sel_ab_o,
    output logic [1:0]  load_index_o,
    output logic [7:0]  in_data_o,
    output logic        output_en_o,
    output logic [1:0]  output_sel_o,
    input  logic [7:0]  out_data_i,
    input  logic        done_i
);

    localparam logic [4:0] TO_LAST  = 5'(DONE_TIMEOUT - 2);
    localparam logic [4:0] GAP_LAST = 5'(READ_DELAY - 2);

    seq_state_t       state_q;
    logic [4:0]       cnt_q;
    logic [4:0]       cnt_inc;
    logic [MAT_W-1:0] a_q;
    logic [MAT_W-1:0] b_q;
    logic [MAT_W-1:0] res_data_q;
    logic             res_valid_q;
    logic             res_timeout_q;
    logic             busy_q;
    logic             load_en_q;
    logic             load_sel_q;
    logic [1:0]       load_idx_q;
    logic [7:0]       in_data_q;
    logic             output_en_q;
    logic [1:0]       output_sel_q;

    assign cnt_inc = cnt_q + 5'd1;

    assign host.cmd_ready   = (state_q == IDLE);
    assign host.res_valid   = res_valid_q;
    assign host.res_data    = res_data_q;
    assign host.res_timeout = res_timeout_q;

    assign busy_o        = busy_q;
    assign load_en_o     = load_en_q;
    assign load_sel_ab_o = load_sel_q;
    assign load_index_o  = load_idx_q;
    assign in_data_o     = in_data_q;
    assign output_en_o   = output_en_q;
    assign output_sel_o  = output_sel_q;

    // Sequencer FSM; every strobe is registered one cycle ahead of use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_data_q    <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            load_en_q     <= 1'b0;
            load_sel_q    <= 1'b0;
            load_idx_q    <= '0;
            in_data_q     <= '0;
            output_en_q   <= 1'b0;
            output_sel_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (host.cmd_valid) begin
                        a_q        <= host.cmd_a;
                        b_q        <= host.cmd_b;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        load_en_q  <= 1'b1;
                        load_sel_q <= SEL_A;
                        load_idx_q <= 2'd0;
                        in_data_q  <= get_elem(host.cmd_a, 2'd0);
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt_q == 5'd7) begin
                        load_en_q  <= 1'b0;
                        load_sel_q <= 1'b0;
                        load_idx_q <= '0;
                        in_data_q  <= '0;
                        cnt_q      <= '0;
                        state_q    <= WAIT_DONE;
                    end else begin
                        cnt_q      <= cnt_inc;
                        load_sel_q <= cnt_inc[2] ? SEL_B : SEL_A;
                        load_idx_q <= cnt_inc[1:0];
                        in_data_q  <= cnt_inc[2]
                                    ? get_elem(b_q, cnt_inc[1:0])
                                    : get_elem(a_q, cnt_inc[1:0]);
                    end
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        cnt_q <= '0;
                        if (READ_DELAY == 1) begin
                            output_en_q  <= 1'b1;
                            output_sel_q <= 2'd0;
                            state_q      <= READ;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        cnt_q         <= '0;
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q        <= '0;
                        output_en_q  <= 1'b1;
                        output_sel_q <= 2'd0;
                        state_q      <= READ;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                READ: begin
                    res_data_q[cnt_q[1:0]*ELEM_W +: ELEM_W] <= out_data_i;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_q         <= '0;
                        output_en_q   <= 1'b0;
                        output_sel_q  <= '0;
                        res_timeout_q <= 1'b0;
                        res_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q        <= cnt_inc;
                        output_sel_q <= cnt_inc[1:0];
                    end
                end
                RESP: begin
                    if (host.res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_timeout_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Self-checking bench for tpu_host_sequencer.
// Includes a behavioural matmul controller and a stub mode with done held low.
module tb_tpu_host_sequencer;
    import tpu_pkg::*;

    localparam int RD = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpu_host_sequencer_if hif();

    logic       busy, load_en, load_sel_ab, output_en, done;
    logic [1:0] load_index, output_sel;
    logic [7:0] in_data, out_data;

    tpu_host_sequencer #(
        .READ_DELAY(RD),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .host(hif),
        .busy_o(busy),
        .load_en_o(load_en),
        .load_sel_ab_o(load_sel_ab),
        .load_index_o(load_index),
        .in_data_o(in_data),
        .output_en_o(output_en),
        .output_sel_o(output_sel),
        .out_data_i(out_data),
        .done_i(done)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] matmul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += int'($signed(a[(2*i+k)*8 +: 8])) * int'($signed(b[(2*k+j)*8 +: 8]));
                if (s > 127) s = 127;
                else if (s < -128) s = -128;
                r[(2*i+j)*8 +: 8] = s[7:0];
            end
        end
        return r;
    endfunction

    // Controller model: done four cycles after the last load, C read combinationally.
    logic        stub = 1'b0;
    logic [31:0] ca, cb, cmat;
    int          cd;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ca   <= '0;
            cb   <= '0;
            cmat <= '0;
            cd   <= 0;
        end else begin
            if (load_en) begin
                if (load_sel_ab) cb[load_index*8 +: 8] <= in_data;
                else             ca[load_index*8 +: 8] <= in_data;
            end
            if (load_en && load_sel_ab && load_index == 2'd3) cd <= 4;
            else if (cd > 0) cd <= cd - 1;
            if (cd == 1) cmat <= matmul(ca, cb);
        end
    end
    assign done     = !stub && (cd == 1);
    assign out_data = cmat[output_sel*8 +: 8];

    int          f_load, l_load, n_load, f_rd, n_rd, sel_bad, resp_t;
    logic [31:0] la, lb;

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        hif.cmd_valid = 1'b1;
        hif.cmd_a     = a;
        hif.cmd_b     = b;
        @(posedge clk); #1;
        hif.cmd_valid = 1'b0;
    endtask

    task automatic track(input int budget);
        f_load = -1; l_load = -1; n_load = 0;
        f_rd = -1; n_rd = 0; sel_bad = 0; resp_t = -1;
        la = '0; lb = '0;
        for (int t = 1; t <= budget; t++) begin
            if (load_en) begin
                if (f_load < 0) f_load = t;
                l_load = t;
                n_load++;
                if (load_sel_ab) lb[load_index*8 +: 8] = in_data;
                else             la[load_index*8 +: 8] = in_data;
            end
            if (output_en) begin
                if (f_rd < 0) f_rd = t;
                if (output_sel != 2'(n_rd)) sel_bad++;
                n_rd++;
            end
            if (hif.res_valid) begin
                resp_t = t;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_check(input string nm, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        send(a, b);
        track(60);
        total++;
        if (f_load != 1 || l_load != 8 || n_load != 8) begin
            bad++;
            $display("FAIL %s load_window got=%0d..%0d n=%0d exp=1..8 n=8", nm, f_load, l_load, n_load);
        end
        total++;
        if (la !== a || lb !== b) begin
            bad++;
            $display("FAIL %s load_data got=%h/%h exp=%h/%h", nm, la, lb, a, b);
        end
        total++;
        if (f_rd != 14 || n_rd != 4 || sel_bad != 0) begin
            bad++;
            $display("FAIL %s reads got first=%0d n=%0d selbad=%0d exp first=14 n=4", nm, f_rd, n_rd, sel_bad);
        end
        total++;
        if (resp_t != 18) begin
            bad++;
            $display("FAIL %s resp_cycle got=%0d exp=18", nm, resp_t);
        end
        total++;
        if (hif.res_data !== exp || hif.res_timeout !== 1'b0) begin
            bad++;
            $display("FAIL %s res_data got=%h to=%b exp=%h to=0", nm, hif.res_data, hif.res_timeout, exp);
        end
        @(posedge clk); #1;
        total++;
        if (hif.res_valid !== 1'b0 || hif.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_hs got v=%b rdy=%b busy=%b exp 0/1/0", nm, hif.res_valid, hif.cmd_ready, busy);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        total++;
        if ({hif.res_valid, hif.res_timeout, busy, load_en, load_sel_ab,
             load_index, in_data, output_en, output_sel} !== '0 ||
            hif.res_data !== 32'h0 || hif.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s outputs got v=%b to=%b d=%h busy=%b le=%b ld=%h oe=%b rdy=%b exp all0 rdy=1",
                     nm, hif.res_valid, hif.res_timeout, hif.res_data, busy, load_en,
                     {load_sel_ab, load_index, in_data}, output_en, hif.cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_basic();
        run_check("basic", 32'h04030201, 32'h08070605, 32'h322B1613);
    endtask

    task automatic test_saturation();
        run_check("pos_sat", 32'h64646464, 32'h64646464, 32'h7F7F7F7F);
        run_check("neg_sat", 32'h9C9C9C9C, 32'h64646464, 32'h80808080);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            run_check("random", a, b, matmul(a, b));
        end
    endtask

    task automatic test_timeout();
        stub = 1'b1;
        send(32'h11223344, 32'h55667788);
        track(60);
        total++;
        if (n_load != 8 || l_load != 8) begin
            bad++;
            $display("FAIL timeout loads got n=%0d last=%0d exp n=8 last=8", n_load, l_load);
        end
        total++;
        if (resp_t != l_load + TO) begin
            bad++;
            $display("FAIL timeout resp_cycle got=%0d exp=%0d", resp_t, l_load + TO);
        end
        total++;
        if (hif.res_timeout !== 1'b1 || hif.res_data !== 32'h0) begin
            bad++;
            $display("FAIL timeout flag got to=%b d=%h exp to=1 d=0", hif.res_timeout, hif.res_data);
        end
        total++;
        if (n_rd != 0) begin
            bad++;
            $display("FAIL timeout no_read got=%0d exp=0", n_rd);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        stub = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, d0;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom;
        hif.res_ready = 1'b0;
        send(a1, b1);
        track(60);
        d0 = hif.res_data;
        total++;
        if (resp_t != 18 || d0 !== matmul(a1, b1)) begin
            bad++;
            $display("FAIL b2b first got t=%0d d=%h exp t=18 d=%h", resp_t, d0, matmul(a1, b1));
        end
        hif.cmd_valid = 1'b1;
        hif.cmd_a     = a2;
        hif.cmd_b     = b2;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (hif.res_valid !== 1'b1 || hif.res_data !== d0 || hif.cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b hold%0d got v=%b d=%h rdy=%b busy=%b exp v=1 d=%h rdy=0 busy=1",
                         k, hif.res_valid, hif.res_data, hif.cmd_ready, busy, d0);
            end
            @(posedge clk); #1;
        end
        hif.res_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (hif.res_valid !== 1'b0 || hif.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b accept_cycle got v=%b rdy=%b exp v=0 rdy=1", hif.res_valid, hif.cmd_ready);
        end
        @(posedge clk); #1;
        hif.cmd_valid = 1'b0;
        track(60);
        total++;
        if (f_load != 1 || resp_t != 18 || la !== a2 || lb !== b2) begin
            bad++;
            $display("FAIL b2b second_timing got fl=%0d t=%0d la=%h lb=%h exp fl=1 t=18 %h/%h",
                     f_load, resp_t, la, lb, a2, b2);
        end
        total++;
        if (hif.res_data !== matmul(a2, b2)) begin
            bad++;
            $display("FAIL b2b second_data got=%h exp=%h", hif.res_data, matmul(a2, b2));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        int seen;
        send(32'hDEADBEEF, 32'h01020304);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (load_en !== 1'b1 || load_sel_ab !== 1'b1 || load_index !== 2'd1 || in_data !== 8'h03) begin
            bad++;
            $display("FAIL midload idx5 got le=%b sel=%b idx=%0d d=%h exp 1/1/1/03",
                     load_en, load_sel_ab, load_index, in_data);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("midload_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            if (hif.res_valid || load_en || output_en) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midload quiet got=%0d exp=0", seen);
        end
        run_check("after_rst", 32'h05FB7F80, 32'h02030405, matmul(32'h05FB7F80, 32'h02030405));
    endtask

    initial begin
        hif.cmd_valid = 1'b0;
        hif.cmd_a     = '0;
        hif.cmd_b     = '0;
        hif.res_ready = 1'b1;
        test_reset();
        test_basic();
        test_saturation();
        test_random();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
